// File: rtl/p32_ctrl_pkg.sv
// Shared encodings for the p32 control sequencer: FSM states, trap cause codes
// and PC source selects.
package p32_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    localparam logic [3:0] CAUSE_INT = 4'd0;
    localparam logic [3:0] CAUSE_IBE = 4'd6;
    localparam logic [3:0] CAUSE_DBE = 4'd7;
    localparam logic [3:0] CAUSE_SYS = 4'd8;
    localparam logic [3:0] CAUSE_RI  = 4'd10;
    localparam logic [3:0] CAUSE_OV  = 4'd12;

    localparam logic [1:0] PC_NEXT   = 2'd0;
    localparam logic [1:0] PC_VECTOR = 2'd1;
    localparam logic [1:0] PC_HOLD   = 2'd2;

endpackage

// File: rtl/p32_mem_timeout.sv
// Memory handshake watchdog: counts request cycles and flags the cycle on which
// the MEM_TIMEOUT-th request cycle is reached.
module p32_mem_timeout #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic m_clock,
    input  logic p_reset,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    logic [15:0] cnt_q;

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            cnt_q <= 16'd0;
        end else if (clr_i) begin
            cnt_q <= 16'd0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    // The counter holds the number of request cycles already elapsed.
    assign timeout_o = en_i && (cnt_q == 16'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/p32_control_sequencer.sv
// Multi-cycle control FSM of the p32 core: fetch, decode, execute, memory,
// writeback and trap entry for one instruction at a time.
module p32_control_sequencer
    import p32_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int IRQ_ENABLE  = 1
) (
    input  logic        m_clock,
    input  logic        p_reset,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        decode,
    input  logic        dec_exception,
    input  logic [3:0]  dec_cause,
    input  logic        dec_mem_read,
    input  logic        dec_mem_write,
    input  logic        dec_reg_write,
    output logic        exec_start,
    input  logic        exec_done,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        reg_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        epc_we,
    output logic        cause_we,
    output logic [3:0]  cause_out,
    input  logic        irq,
    output logic [2:0]  state_out,
    output logic [31:0] retired
);

    state_e      state_q;
    logic [3:0]  cause_q;
    logic [31:0] retired_q;
    logic        load_q;
    logic        store_q;
    logic        regw_q;
    logic        exec_first_q;
    logic        tmo_en;
    logic        tmo_clr;
    logic        tmo_hit;
    logic        irq_take;

    // One watchdog serves both FETCH and MEM; it restarts whenever the
    // request phase ends or is not active.
    assign tmo_en  = (state_q == S_FETCH) || (state_q == S_MEM);
    assign tmo_clr = !tmo_en || tmo_hit
                   || ((state_q == S_FETCH) && imem_ack)
                   || ((state_q == S_MEM) && dmem_ack);
    assign irq_take = (IRQ_ENABLE != 0) && irq;

    p32_mem_timeout #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_tmo (
        .m_clock  (m_clock),
        .p_reset  (p_reset),
        .clr_i    (tmo_clr),
        .en_i     (tmo_en),
        .timeout_o(tmo_hit)
    );

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            state_q      <= S_IDLE;
            cause_q      <= CAUSE_INT;
            retired_q    <= 32'd0;
            load_q       <= 1'b0;
            store_q      <= 1'b0;
            regw_q       <= 1'b0;
            exec_first_q <= 1'b0;
        end else begin
            exec_first_q <= 1'b0;
            case (state_q)
                S_IDLE: if (run) state_q <= S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        state_q <= S_DECODE;
                    end else if (tmo_hit) begin
                        state_q <= S_TRAP;
                        cause_q <= CAUSE_IBE;
                    end
                end
                S_DECODE: begin
                    load_q  <= dec_mem_read;
                    store_q <= dec_mem_write;
                    regw_q  <= dec_reg_write;
                    if (dec_exception) begin
                        state_q <= S_TRAP;
                        cause_q <= dec_cause;
                    end else begin
                        state_q      <= S_EXEC;
                        exec_first_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (exec_done) state_q <= (load_q || store_q) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        state_q <= S_WB;
                    end else if (tmo_hit) begin
                        state_q <= S_TRAP;
                        cause_q <= CAUSE_DBE;
                    end
                end
                S_WB: begin
                    retired_q <= retired_q + 32'd1;
                    if (irq_take) begin
                        state_q <= S_TRAP;
                        cause_q <= CAUSE_INT;
                    end else begin
                        state_q <= run ? S_FETCH : S_IDLE;
                    end
                end
                S_TRAP:  state_q <= run ? S_FETCH : S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Every output is decoded from registered state only.
    assign imem_req   = (state_q == S_FETCH);
    assign decode     = (state_q == S_DECODE);
    assign exec_start = (state_q == S_EXEC) && exec_first_q;
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = (state_q == S_MEM) && store_q;
    assign reg_we     = (state_q == S_WB) && regw_q;
    assign pc_we      = (state_q == S_WB) || (state_q == S_TRAP);
    assign pc_sel     = (state_q == S_WB)   ? PC_NEXT :
                        (state_q == S_TRAP) ? PC_VECTOR : PC_HOLD;
    assign epc_we     = (state_q == S_TRAP);
    assign cause_we   = (state_q == S_TRAP);
    assign cause_out  = cause_q;
    assign state_out  = state_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_p32_control_sequencer.sv
// Bench for p32_control_sequencer: two instances (interrupts enabled/disabled)
// share stimulus and are compared every cycle against a behavioural model.
module tb_p32_control_sequencer;

    localparam int TMO = 4;

    logic       m_clock = 1'b0;
    logic       p_reset = 1'b0;
    logic       run = 1'b0;
    logic       imem_ack = 1'b0;
    logic       dec_exception = 1'b0;
    logic [3:0] dec_cause = 4'd0;
    logic       dec_mem_read = 1'b0;
    logic       dec_mem_write = 1'b0;
    logic       dec_reg_write = 1'b0;
    logic       exec_done = 1'b0;
    logic       dmem_ack = 1'b0;
    logic       irq = 1'b0;

    logic        imem_req_w [2];
    logic        decode_w [2];
    logic        exec_start_w [2];
    logic        dmem_req_w [2];
    logic        dmem_we_w [2];
    logic        reg_we_w [2];
    logic        pc_we_w [2];
    logic [1:0]  pc_sel_w [2];
    logic        epc_we_w [2];
    logic        cause_we_w [2];
    logic [3:0]  cause_w [2];
    logic [2:0]  state_w [2];
    logic [31:0] ret_w [2];

    always #5 m_clock = ~m_clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        p32_control_sequencer #(
            .MEM_TIMEOUT(TMO),
            .IRQ_ENABLE ((g == 0) ? 1 : 0)
        ) dut (
            .m_clock      (m_clock),
            .p_reset      (p_reset),
            .run          (run),
            .imem_req     (imem_req_w[g]),
            .imem_ack     (imem_ack),
            .decode       (decode_w[g]),
            .dec_exception(dec_exception),
            .dec_cause    (dec_cause),
            .dec_mem_read (dec_mem_read),
            .dec_mem_write(dec_mem_write),
            .dec_reg_write(dec_reg_write),
            .exec_start   (exec_start_w[g]),
            .exec_done    (exec_done),
            .dmem_req     (dmem_req_w[g]),
            .dmem_we      (dmem_we_w[g]),
            .dmem_ack     (dmem_ack),
            .reg_we       (reg_we_w[g]),
            .pc_we        (pc_we_w[g]),
            .pc_sel       (pc_sel_w[g]),
            .epc_we       (epc_we_w[g]),
            .cause_we     (cause_we_w[g]),
            .cause_out    (cause_w[g]),
            .irq          (irq),
            .state_out    (state_w[g]),
            .retired      (ret_w[g])
        );
    end

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: phase of the instruction, cycles spent in that phase,
    // decoded attributes, pending trap code and the retirement count.
    int          m_st [2];
    int          m_cis [2];
    bit          m_rd [2];
    bit          m_wr [2];
    bit          m_rw [2];
    int          m_cause [2];
    logic [31:0] m_ret [2];

    always @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            for (int k = 0; k < 2; k++) begin
                m_st[k] = 0; m_cis[k] = 0; m_rd[k] = 0; m_wr[k] = 0; m_rw[k] = 0;
                m_cause[k] = 0; m_ret[k] = 32'd0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int nx;
                nx = m_st[k];
                case (m_st[k])
                    0: if (run) nx = 1;
                    1: if (imem_ack) nx = 2;
                       else if (m_cis[k] + 1 >= TMO) begin nx = 6; m_cause[k] = 6; end
                    2: begin
                        m_rd[k] = dec_mem_read; m_wr[k] = dec_mem_write; m_rw[k] = dec_reg_write;
                        if (dec_exception) begin nx = 6; m_cause[k] = int'(dec_cause); end
                        else nx = 3;
                    end
                    3: if (exec_done) nx = (m_rd[k] || m_wr[k]) ? 4 : 5;
                    4: if (dmem_ack) nx = 5;
                       else if (m_cis[k] + 1 >= TMO) begin nx = 6; m_cause[k] = 7; end
                    5: begin
                        m_ret[k] = m_ret[k] + 32'd1;
                        if (k == 0 && irq) begin nx = 6; m_cause[k] = 0; end
                        else nx = run ? 1 : 0;
                    end
                    default: nx = run ? 1 : 0;
                endcase
                m_cis[k] = (nx == m_st[k]) ? m_cis[k] + 1 : 0;
                m_st[k] = nx;
            end
        end
    end

    // Environment responders: ack/done after a configured number of wait cycles (-1 = never).
    int imem_dly = 0;
    int exec_dly = 0;
    int dmem_dly = 0;

    always @(posedge m_clock) begin
        #1;
        imem_ack  = (m_st[0] == 1) && (imem_dly >= 0) && (m_cis[0] == imem_dly);
        exec_done = (m_st[0] == 3) && (exec_dly >= 0) && (m_cis[0] == exec_dly);
        dmem_ack  = (m_st[0] == 4) && (dmem_dly >= 0) && (m_cis[0] == dmem_dly);
    end

    always @(negedge m_clock) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d state", k), 32'(state_w[k]), 32'(m_st[k]));
            chk($sformatf("d%0d imem_req", k), 32'(imem_req_w[k]), 32'(m_st[k] == 1));
            chk($sformatf("d%0d decode", k), 32'(decode_w[k]), 32'(m_st[k] == 2));
            chk($sformatf("d%0d exec_start", k), 32'(exec_start_w[k]), 32'(m_st[k] == 3 && m_cis[k] == 0));
            chk($sformatf("d%0d dmem_req", k), 32'(dmem_req_w[k]), 32'(m_st[k] == 4));
            chk($sformatf("d%0d dmem_we", k), 32'(dmem_we_w[k]), 32'(m_st[k] == 4 && m_wr[k]));
            chk($sformatf("d%0d reg_we", k), 32'(reg_we_w[k]), 32'(m_st[k] == 5 && m_rw[k]));
            chk($sformatf("d%0d pc_we", k), 32'(pc_we_w[k]), 32'(m_st[k] == 5 || m_st[k] == 6));
            chk($sformatf("d%0d pc_sel", k), 32'(pc_sel_w[k]), (m_st[k] == 5) ? 0 : (m_st[k] == 6) ? 1 : 2);
            chk($sformatf("d%0d epc_we", k), 32'(epc_we_w[k]), 32'(m_st[k] == 6));
            chk($sformatf("d%0d cause_we", k), 32'(cause_we_w[k]), 32'(m_st[k] == 6));
            if (m_st[k] == 6 || p_reset)
                chk($sformatf("d%0d cause_out", k), 32'(cause_w[k]), m_cause[k]);
            chk($sformatf("d%0d retired", k), ret_w[k], m_ret[k]);
        end
    end

    // Per-scenario tallies of DUT strobes, sampled away from the clock edge.
    int          c_ireq, c_dreq, c_dwe, c_rwe, c_pwe, c_xs, c_cwe0, c_cwe1;
    logic [3:0]  last_cause0;
    logic [31:0] seq;
    logic [2:0]  last_st;

    task automatic tick();
        @(posedge m_clock);
        #2;
        if (imem_req_w[0])   c_ireq++;
        if (dmem_req_w[0])   c_dreq++;
        if (dmem_we_w[0])    c_dwe++;
        if (reg_we_w[0])     c_rwe++;
        if (pc_we_w[0])      c_pwe++;
        if (exec_start_w[0]) c_xs++;
        if (cause_we_w[0]) begin c_cwe0++; last_cause0 = cause_w[0]; end
        if (cause_we_w[1])   c_cwe1++;
        if (state_w[0] != last_st) begin
            seq = {seq[28:0], state_w[0]};
            last_st = state_w[0];
        end
    endtask

    task automatic wait_st(input int s, input string nm);
        int n;
        n = 0;
        while (m_st[0] != s && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            nchk++;
            nerr++;
            $display("FAIL %s: wait for state %0d expired, model state %0d", nm, s, m_st[0]);
        end
    endtask

    task automatic cfg(input int im, input int ex, input int dm, input bit rd, input bit wr,
                       input bit rw, input bit exc, input logic [3:0] cs);
        imem_dly = im; exec_dly = ex; dmem_dly = dm;
        dec_mem_read = rd; dec_mem_write = wr; dec_reg_write = rw;
        dec_exception = exc; dec_cause = cs;
        c_ireq = 0; c_dreq = 0; c_dwe = 0; c_rwe = 0; c_pwe = 0; c_xs = 0;
        c_cwe0 = 0; c_cwe1 = 0; last_cause0 = 4'hf;
        seq = 32'd0; last_st = 3'd0;
    endtask

    task automatic go(input string nm);
        run = 1'b1;
        tick();
        run = 1'b0;
        wait_st(0, nm);
    endtask

    initial begin
        #1 p_reset = 1'b1;
        repeat (3) @(posedge m_clock);
        #3 p_reset = 1'b0;
        tick();
        chk("reset state", 32'(state_w[0]), 0);
        chk("reset pc_sel", 32'(pc_sel_w[0]), 2);

        // ALU op: fetch acked after 2 wait cycles, exec done immediately
        cfg(2, 0, 0, 0, 0, 1, 0, 4'd0);
        go("alu");
        chk("alu state sequence", seq, 32'o12350);
        chk("alu imem_req cycles", c_ireq, 3);
        chk("alu reg_we pulses", c_rwe, 1);
        chk("alu pc_we pulses", c_pwe, 1);
        chk("alu retired", ret_w[0], 1);

        // Load: dmem_ack after 3 wait cycles
        cfg(0, 0, 3, 1, 0, 1, 0, 4'd0);
        go("load");
        chk("load dmem_req cycles", c_dreq, 4);
        chk("load dmem_we cycles", c_dwe, 0);
        chk("load reg_we pulses", c_rwe, 1);
        chk("load retired", ret_w[0], 2);

        // Store
        cfg(0, 0, 1, 0, 1, 0, 0, 4'd0);
        go("store");
        chk("store dmem_req cycles", c_dreq, 2);
        chk("store dmem_we cycles", c_dwe, 2);
        chk("store reg_we pulses", c_rwe, 0);
        chk("store retired", ret_w[0], 3);

        // Decode exception (RI) with run held: TRAP then FETCH
        cfg(0, 0, 0, 0, 0, 1, 1, 4'd10);
        run = 1'b1;
        wait_st(6, "dec trap");
        chk("dec trap cause_out", 32'(cause_w[0]), 10);
        chk("dec trap epc_we", 32'(epc_we_w[0]), 1);
        chk("dec trap pc_sel", 32'(pc_sel_w[0]), 1);
        chk("dec trap reg_we", 32'(reg_we_w[0]), 0);
        chk("dec trap retired", ret_w[0], 3);
        tick();
        chk("dec trap then fetch", 32'(state_w[0]), 1);
        run = 1'b0;
        wait_st(0, "dec trap idle");
        chk("dec trap count", c_cwe0, 2);
        chk("dec trap retired after", ret_w[0], 3);

        // Instruction bus timeout
        cfg(-1, 0, 0, 0, 0, 1, 0, 4'd0);
        go("ibe");
        chk("ibe req cycles", c_ireq, TMO);
        chk("ibe cause", 32'(last_cause0), 6);
        chk("ibe retired", ret_w[0], 3);

        // Data bus timeout on a load
        cfg(0, 0, -1, 1, 0, 1, 0, 4'd0);
        go("dbe");
        chk("dbe req cycles", c_dreq, TMO);
        chk("dbe cause", 32'(last_cause0), 7);
        chk("dbe reg_we pulses", c_rwe, 0);
        chk("dbe retired", ret_w[0], 3);

        // Acks on the last allowed cycle count as success
        cfg(3, 0, 3, 1, 0, 1, 0, 4'd0);
        go("late ack");
        chk("late ack imem cycles", c_ireq, 4);
        chk("late ack dmem cycles", c_dreq, 4);
        chk("late ack no trap", c_cwe0, 0);
        chk("late ack retired", ret_w[0], 4);

        // run dropped during EXEC: instruction still completes
        cfg(0, 3, 0, 0, 0, 1, 0, 4'd0);
        run = 1'b1;
        wait_st(3, "run drop exec");
        run = 1'b0;
        wait_st(0, "run drop idle");
        chk("run drop exec_start pulses", c_xs, 1);
        chk("run drop retired", ret_w[0], 5);
        chk("run drop idle state", 32'(state_w[0]), 0);

        // irq held: retire then interrupt trap on the enabled instance only
        cfg(0, 0, 0, 0, 0, 1, 0, 4'd0);
        irq = 1'b1;
        go("irq");
        irq = 1'b0;
        chk("irq trap count", c_cwe0, 1);
        chk("irq cause", 32'(last_cause0), 0);
        chk("irq retired", ret_w[0], 6);
        chk("irq disabled trap count", c_cwe1, 0);
        chk("irq disabled retired", ret_w[1], 6);

        // Reset in the middle of a data access
        cfg(0, 0, -1, 1, 0, 1, 0, 4'd0);
        run = 1'b1;
        tick();
        run = 1'b0;
        wait_st(4, "reset mem");
        tick();
        chk("pre-reset dmem_req", 32'(dmem_req_w[0]), 1);
        @(posedge m_clock);
        #3 p_reset = 1'b1;
        #1;
        chk("mid reset dmem_req", 32'(dmem_req_w[0]), 0);
        chk("mid reset state", 32'(state_w[0]), 0);
        chk("mid reset retired", ret_w[0], 0);
        repeat (2) @(posedge m_clock);
        #3 p_reset = 1'b0;

        cfg(0, 0, 0, 0, 0, 1, 0, 4'd0);
        go("after reset");
        chk("after reset retired", ret_w[0], 1);
        chk("after reset reg_we pulses", c_rwe, 1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/p32_control_sequencer.md
Name: p32_control_sequencer

Overview:
Multi-cycle control FSM for the p32 core. It sequences fetch, decode, execute, memory and writeback for one instruction at a time. It strobes the decode unit and consumes its classification and exception flags. It handles instruction/data memory handshakes with a timeout, external interrupts, and trap entry (EPC/Cause write, vector PC select).

Parameters:
MEM_TIMEOUT, 16, cycles to wait for imem_ack/dmem_ack before raising a bus error (1..65535)
IRQ_ENABLE, 1, 0 = irq input ignored

Ports:
m_clock  in  1  clock
p_reset  in  1  reset, asynchronous, active-high
run  in  1  level; while low, FSM parks in IDLE after finishing the current instruction
imem_req  out  1  instruction fetch request, held until ack
imem_ack  in  1  fetch data valid (inst latched by datapath)
decode  out  1  one-cycle decode strobe to decode unit
dec_exception  in  1  decode unit exception flag (valid in DECODE)
dec_cause  in  4  decode unit cause code (valid when dec_exception)
dec_mem_read  in  1  instruction is a load
dec_mem_write  in  1  instruction is a store
dec_reg_write  in  1  instruction writes a GPR
exec_start  out  1  one-cycle ALU/branch start
exec_done  in  1  execution result ready
dmem_req  out  1  data memory request, held until ack
dmem_we  out  1  write qualifier for dmem_req
dmem_ack  in  1  data access complete
reg_we  out  1  one-cycle GPR write enable
pc_we  out  1  one-cycle PC update enable
pc_sel  out  2  0 = next/branch (datapath), 1 = exception vector, 2 = hold
epc_we  out  1  one-cycle EPC write (set_epc)
cause_we  out  1  one-cycle Cause write (set_cause)
cause_out  out  4  cause code, valid with cause_we
irq  in  1  level interrupt request
state_out  out  3  current state encoding (debug)
retired  out  32  count of completed instructions

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Reset (async): state IDLE, all strobes/req 0, pc_sel 2, cause_out 0, retired 0, timeout counter 0, mem-op latches 0.
- IDLE: when run=1, go to FETCH next cycle.
- FETCH: imem_req=1. On imem_ack, go to DECODE. If ack is absent for MEM_TIMEOUT cycles (counter counts req cycles; trap when counter reaches MEM_TIMEOUT): TRAP with cause 6 (IBE).
- DECODE: decode=1 for exactly this cycle; latch dec_mem_read/write/reg_write. If dec_exception: TRAP with cause dec_cause. Otherwise go to EXEC.
- EXEC: exec_start=1 on the first EXEC cycle only. Wait for exec_done (may come in the same cycle as exec_start). Then go to MEM if a load/store was latched, else WB.
- MEM: dmem_req=1; dmem_we=latched store. On dmem_ack, go to WB. On timeout: TRAP with cause 7 (DBE).
- WB: reg_we=latched reg_write; pc_we=1, pc_sel=0; retired += 1 (wraps at 2^32). Next state:
  - TRAP with cause 0 if IRQ_ENABLE and irq sampled high in WB;
  - else FETCH if run=1;
  - else IDLE.
- TRAP, one cycle: epc_we=1, cause_we=1, pc_we=1, pc_sel=1, cause_out=latched code; reg_we=0. Go to FETCH if run=1, else IDLE. Trapped instructions do not increment retired.
- Simultaneous events:
  - dec_exception outranks everything in DECODE.
  - An ack arriving in the same cycle the counter hits MEM_TIMEOUT counts as success.
  - irq is sampled only in WB, so irq during an outstanding memory access is deferred.
  - irq during TRAP is ignored until the next WB.
- Timeout counter clears on every state entry. No req is dropped before ack or timeout; an ack arriving in a state without req is ignored.
- Reset mid-transaction aborts it immediately. The memory side must tolerate req dropping.
- pc_sel=2 in all states other than WB and TRAP. All outputs are registered or state-decoded; no combinational path from dmem_ack or imem_ack to req.

Decomposition:
- Shared package p32_ctrl_pkg holds:
  - state encodings;
  - cause codes (INT=0, IBE=6, DBE=7, SYS=8, RI=10, OV=12);
  - pc_sel encodings.
- One sub-module is natural: p32_mem_timeout (counter with clear/enable, timeout flag), instantiated once and shared by FETCH and MEM.

Test Plan:
- Reset, run=1, imem_ack 2 cycles after req, exec_done same cycle, ALU op with dec_reg_write=1 -> state sequence 1,2,3,5; reg_we and pc_we pulse once in WB; retired=1.
- Load with dmem_ack after 3 cycles -> MEM held 4 cycles with dmem_req=1, dmem_we=0; then WB with reg_we=1. Store -> dmem_we=1, reg_we=0.
- dec_exception=1, dec_cause=10 in DECODE -> TRAP next cycle: epc_we=cause_we=pc_we=1, pc_sel=1, cause_out=10; retired unchanged; then FETCH.
- imem_ack never asserted, MEM_TIMEOUT=4 -> TRAP with cause_out=6 after 4 req cycles. Repeat in MEM -> cause_out=7. Ack on the 4th cycle -> no trap.
- irq=1 held throughout an instruction -> instruction retires (retired+1), then TRAP with cause_out=0. With IRQ_ENABLE=0 -> no trap.
- run dropped mid-EXEC -> instruction completes WB, then IDLE with state_out=0. p_reset asserted in MEM -> dmem_req=0 immediately, state 0.
